// File: rtl/button_pkg.sv
// ============================================================================
//  Module : button_pkg
//  Brief  : Shared defaults, FSM encodings and counter-width helper for button_bank.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package button_pkg;

  localparam int DEF_N_CH     = 4;
  localparam int DEF_DB_TICKS = 15;
  localparam int DEF_LP_TICKS = 200;
  localparam int DEF_CW       = 8;

  localparam int         c_ST_W       = 2;
  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_PRESSED = 2'd1;
  localparam logic [1:0] c_ST_LONG    = 2'd2;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_channel.sv
// ============================================================================
//  Module : button_channel
//  Brief  : One button: 2-FF sync, tick-sampled debounce, press edge, counter, long press.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module button_channel
  import button_pkg::*;
#(
  parameter int DB_TICKS = DEF_DB_TICKS,
  parameter int LP_TICKS = DEF_LP_TICKS,
  parameter int CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          i_reset_n,
  input  logic          i_tick,
  input  logic          i_btn,
  input  logic          i_clr_count,
  output logic          o_btn_level,
  output logic          o_press_pulse,
  output logic          o_long_press,
  output logic [CW-1:0] o_count
);

  localparam int                c_DBW     = cnt_width(DB_TICKS - 1);
  localparam int                c_LPW     = cnt_width(LP_TICKS - 1);
  localparam logic [c_DBW-1:0]  c_DB_LAST = c_DBW'(DB_TICKS - 1);
  localparam logic [c_LPW-1:0]  c_LP_LAST = c_LPW'(LP_TICKS - 1);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic [c_DBW-1:0]  db_cnt_q, db_cnt_d;
  logic [c_LPW-1:0]  lp_cnt_q, lp_cnt_d;
  logic [c_ST_W-1:0] state_q, state_d;
  logic              level_prev_q, level_prev_d;
  logic              pulse_q, pulse_d;
  logic [CW-1:0]     count_q, count_d;

  logic w_stable;
  logic w_long;
  logic w_differ;
  logic w_accept;
  logic w_lp_done;

  // State register plus all datapath flops.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      db_cnt_q     <= '0;
      lp_cnt_q     <= '0;
      state_q      <= c_ST_IDLE;
      level_prev_q <= 1'b0;
      pulse_q      <= 1'b0;
      count_q      <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      db_cnt_q     <= db_cnt_d;
      lp_cnt_q     <= lp_cnt_d;
      state_q      <= state_d;
      level_prev_q <= level_prev_d;
      pulse_q      <= pulse_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    sync1_d   = i_btn;
    sync2_d   = sync1_q;
    w_differ  = (sync2_q != w_stable);
    w_accept  = i_tick && w_differ && (db_cnt_q == c_DB_LAST);
    w_lp_done = i_tick && (lp_cnt_q == c_LP_LAST);

    // A matching sample restarts the run; non-tick cycles hold everything.
    db_cnt_d = db_cnt_q;
    if (i_tick) begin
      db_cnt_d = (w_differ && !w_accept) ? db_cnt_q + 1'b1 : '0;
    end

    lp_cnt_d = lp_cnt_q;
    if ((state_q == c_ST_IDLE) || w_accept) begin
      lp_cnt_d = '0;
    end else if ((state_q == c_ST_PRESSED) && i_tick && !w_lp_done) begin
      lp_cnt_d = lp_cnt_q + 1'b1;
    end

    level_prev_d = w_stable;
    pulse_d      = w_stable && !level_prev_q;

    count_d = count_q;
    if (i_clr_count) begin
      count_d = '0;
    end else if (pulse_q) begin
      count_d = count_q + 1'b1;
    end
  end

  // Next state: an accepted debounce change always wins over the long-press timer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: begin
        if (w_accept) state_d = c_ST_PRESSED;
      end
      c_ST_PRESSED: begin
        if (w_accept)       state_d = c_ST_IDLE;
        else if (w_lp_done) state_d = c_ST_LONG;
      end
      c_ST_LONG: begin
        if (w_accept) state_d = c_ST_IDLE;
      end
      default: state_d = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_stable = (state_q != c_ST_IDLE);
    w_long   = (state_q == c_ST_LONG);
  end

  assign o_btn_level   = w_stable;
  assign o_long_press  = w_long;
  assign o_press_pulse = pulse_q;
  assign o_count       = count_q;

endmodule

`default_nettype wire

// File: rtl/button_bank.sv
// ============================================================================
//  Module : button_bank
//  Brief  : N_CH-channel push-button front end with optional active-low pins.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module button_bank
  import button_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int DB_TICKS   = DEF_DB_TICKS,
  parameter int CW         = DEF_CW,
  parameter int LP_TICKS   = DEF_LP_TICKS,
  parameter int ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [N_CH-1:0]    btn_in,
  input  logic [N_CH-1:0]    clr_count,
  output logic [N_CH-1:0]    btn_level,
  output logic [N_CH-1:0]    press_pulse,
  output logic [N_CH-1:0]    long_press,
  output logic [N_CH*CW-1:0] count
);

  logic [N_CH-1:0] w_btn;

  assign w_btn = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      button_channel #(
        .DB_TICKS (DB_TICKS),
        .LP_TICKS (LP_TICKS),
        .CW       (CW)
      ) u_channel (
        .clk           (clk),
        .i_reset_n     (reset),
        .i_tick        (tick),
        .i_btn         (w_btn[i]),
        .i_clr_count   (clr_count[i]),
        .o_btn_level   (btn_level[i]),
        .o_press_pulse (press_pulse[i]),
        .o_long_press  (long_press[i]),
        .o_count       (count[i*CW +: CW])
      );
    end
  endgenerate

endmodule

`default_nettype wire
